// File: rtl/modulo_arbiter_if.sv
// Requester and core-side bundle for modulo_arbiter.
// slave = arbiter side, master = clients plus modulo core.
interface modulo_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*WIDTH-1:0] zahl1_i;
    logic [N_REQ*WIDTH-1:0] zahl2_i;
    logic [N_REQ-1:0]       done_o;
    logic                   err_o;
    logic [WIDTH-1:0]       ergebnis_o;
    logic [IDW-1:0]         grant_id_o;
    logic                   busy_o;
    logic                   core_start_o;
    logic [WIDTH-1:0]       core_zahl1_o;
    logic [WIDTH-1:0]       core_zahl2_o;
    logic                   core_valid_i;
    logic [WIDTH-1:0]       core_ergebnis_i;

    modport slave (
        input  req_i, zahl1_i, zahl2_i, core_valid_i, core_ergebnis_i,
        output done_o, err_o, ergebnis_o, grant_id_o, busy_o,
               core_start_o, core_zahl1_o, core_zahl2_o
    );

    modport master (
        output req_i, zahl1_i, zahl2_i, core_valid_i, core_ergebnis_i,
        input  done_o, err_o, ergebnis_o, grant_id_o, busy_o,
               core_start_o, core_zahl1_o, core_zahl2_o
    );
endinterface

// File: rtl/modulo_arbiter.sv
// Round-robin front end sharing one modulo core between N_REQ requesters.
// Optional WAIT watchdog enabled by defining MODULO_ARBITER_TIMEOUT_EN.
module modulo_arbiter #(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    modulo_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);

    generate
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
            $error("modulo_arbiter: N_REQ must be 2..8");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("modulo_arbiter: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   rr_ptr, grant_id, win;
    logic [IDW:0]     cand;
    logic             found;
    logic [WIDTH-1:0] zahl1_q, zahl2_q, ergebnis_q;
    logic             err_q;
    logic [N_REQ-1:0] done_vec;
    logic             to_hit;

    logic [WIDTH-1:0] z1_arr [N_REQ];
    logic [WIDTH-1:0] z2_arr [N_REQ];

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_slice
            assign z1_arr[g] = bus.zahl1_i[g*WIDTH +: WIDTH];
            assign z2_arr[g] = bus.zahl2_i[g*WIDTH +: WIDTH];
        end
    endgenerate

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win   = rr_ptr;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!found && bus.req_i[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

`ifdef MODULO_ARBITER_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt;

    // Counts completed WAIT cycles; to_hit marks the last permitted one.
    assign to_hit = (state == WAIT) && (to_cnt == TOW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        to_cnt <= '0;
        else if (state == WAIT && !to_hit) to_cnt <= to_cnt + TOW'(1);
        else                             to_cnt <= '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n  = state;
        done_vec = '0;
        case (state)
            IDLE:  if (found) state_n = (z2_arr[win] == '0) ? DONE : ISSUE;
            ISSUE: state_n = WAIT;
            WAIT:  if (bus.core_valid_i || to_hit) state_n = DONE;
            DONE: begin
                state_n            = IDLE;
                done_vec[grant_id] = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operands, result and pointer; a zero divisor completes without the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            zahl1_q    <= '0;
            zahl2_q    <= '0;
            ergebnis_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant_id <= win;
                    zahl1_q  <= z1_arr[win];
                    zahl2_q  <= z2_arr[win];
                    if (z2_arr[win] == '0) begin
                        ergebnis_q <= '0;
                        err_q      <= 1'b1;
                    end
                end
                WAIT: if (bus.core_valid_i) begin
                    ergebnis_q <= bus.core_ergebnis_i;
                    err_q      <= 1'b0;
                end else if (to_hit) begin
                    ergebnis_q <= '0;
                    err_q      <= 1'b1;
                end
                DONE: rr_ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
                default: ;
            endcase
        end
    end

    assign bus.done_o       = done_vec;
    assign bus.err_o        = err_q;
    assign bus.ergebnis_o   = ergebnis_q;
    assign bus.grant_id_o   = grant_id;
    assign bus.busy_o       = (state != IDLE);
    assign bus.core_start_o = (state == ISSUE);
    assign bus.core_zahl1_o = zahl1_q;
    assign bus.core_zahl2_o = zahl2_q;
endmodule
